// File: rtl/wb8_master_arbiter.sv
// wb8_master_arbiter: round-robin Wishbone 8-bit arbiter, m0 = CPU, m1 = DMA, one slave port, one-hot O_grant, bus timeout raises O_mk_err
module wb8_master_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        I_wb_clk,
  input  logic        I_reset_n,
  input  logic        I_m0_cyc,
  input  logic        I_m0_stb,
  input  logic        I_m0_we,
  input  logic [31:0] I_m0_adr,
  input  logic [7:0]  I_m0_dat,
  output logic [7:0]  O_m0_dat,
  output logic        O_m0_ack,
  output logic        O_m0_stall,
  output logic        O_m0_err,
  input  logic        I_m1_cyc,
  input  logic        I_m1_stb,
  input  logic        I_m1_we,
  input  logic [31:0] I_m1_adr,
  input  logic [7:0]  I_m1_dat,
  output logic [7:0]  O_m1_dat,
  output logic        O_m1_ack,
  output logic        O_m1_stall,
  output logic        O_m1_err,
  output logic        O_s_cyc,
  output logic        O_s_stb,
  output logic        O_s_we,
  output logic [31:0] O_s_adr,
  output logic [7:0]  O_s_dat,
  input  logic [7:0]  I_s_dat,
  input  logic        I_s_ack,
  input  logic        I_s_stall,
  output logic [1:0]  O_grant
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic last_q, last_d, err_q, err_d, own0, own1, own, o_cyc, o_stb;
  logic [15:0] cnt_q, cnt_d;
  assign own0  = state_q == OWN0;
  assign own1  = state_q == OWN1;
  assign own   = own0 | own1;
  assign o_cyc = own1 ? I_m1_cyc : I_m0_cyc;
  assign o_stb = own1 ? I_m1_stb : I_m0_stb;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (I_m0_cyc && (!I_m1_cyc || last_q)) ? OWN0 : I_m1_cyc ? OWN1 : IDLE;
    else if (!o_cyc || err_q)
      state_d = own0 ? (I_m1_cyc ? OWN1 : IDLE) : (I_m0_cyc ? OWN0 : IDLE);
    last_d = state_d == OWN0 ? 1'b0 : state_d == OWN1 ? 1'b1 : last_q;
    // the error cycle always leaves the state, so the counter clears through the grant-change term
    err_d = own && o_cyc && !err_q && !I_s_ack && cnt_q == T_LAST;
    cnt_d = (!own || I_s_ack || state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
  end
  always_ff @(posedge I_wb_clk) begin
    if (!I_reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign O_grant    = {own1, own0};
  assign O_s_cyc    = own && !err_q && o_cyc;
  assign O_s_stb    = own && !err_q && o_stb;
  assign O_s_we     = own && (own1 ? I_m1_we : I_m0_we);
  assign O_s_adr    = own1 ? I_m1_adr : I_m0_adr;
  assign O_s_dat    = own1 ? I_m1_dat : I_m0_dat;
  assign O_m0_dat   = I_s_dat;
  assign O_m1_dat   = I_s_dat;
  assign O_m0_ack   = own0 && !err_q && I_s_ack;
  assign O_m1_ack   = own1 && !err_q && I_s_ack;
  assign O_m0_stall = own0 ? I_s_stall : 1'b1;
  assign O_m1_stall = own1 ? I_s_stall : 1'b1;
  assign O_m0_err   = own0 && err_q;
  assign O_m1_err   = own1 && err_q;
endmodule

// File: tb/tb_wb8_master_arbiter.sv
// tb_wb8_master_arbiter: directed checks of arbitration, isolation, timeout and reset
module tb_wb8_master_arbiter;
  logic clk = 0, rst_n = 0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m1_adr = 0;
  logic [7:0] m0_dat = 0, m1_dat = 0, s_dat_i = 0;
  logic s_ack = 0, s_stall = 0;
  logic [7:0] d_m0_dat, d_m1_dat, d_s_dat, t_m0_dat, t_m1_dat, t_s_dat;
  logic d_m0_ack, d_m0_stall, d_m0_err, d_m1_ack, d_m1_stall, d_m1_err, d_s_cyc, d_s_stb, d_s_we;
  logic t_m0_ack, t_m0_stall, t_m0_err, t_m1_ack, t_m1_stall, t_m1_err, t_s_cyc, t_s_stb, t_s_we;
  logic [31:0] d_s_adr, t_s_adr;
  logic [1:0] d_grant, t_grant;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  wb8_master_arbiter dut (
    .I_wb_clk(clk), .I_reset_n(rst_n),
    .I_m0_cyc(m0_cyc), .I_m0_stb(m0_stb), .I_m0_we(m0_we), .I_m0_adr(m0_adr), .I_m0_dat(m0_dat),
    .O_m0_dat(d_m0_dat), .O_m0_ack(d_m0_ack), .O_m0_stall(d_m0_stall), .O_m0_err(d_m0_err),
    .I_m1_cyc(m1_cyc), .I_m1_stb(m1_stb), .I_m1_we(m1_we), .I_m1_adr(m1_adr), .I_m1_dat(m1_dat),
    .O_m1_dat(d_m1_dat), .O_m1_ack(d_m1_ack), .O_m1_stall(d_m1_stall), .O_m1_err(d_m1_err),
    .O_s_cyc(d_s_cyc), .O_s_stb(d_s_stb), .O_s_we(d_s_we), .O_s_adr(d_s_adr), .O_s_dat(d_s_dat),
    .I_s_dat(s_dat_i), .I_s_ack(s_ack), .I_s_stall(s_stall), .O_grant(d_grant)
  );
  wb8_master_arbiter #(.TIMEOUT(4)) dt (
    .I_wb_clk(clk), .I_reset_n(rst_n),
    .I_m0_cyc(m0_cyc), .I_m0_stb(m0_stb), .I_m0_we(m0_we), .I_m0_adr(m0_adr), .I_m0_dat(m0_dat),
    .O_m0_dat(t_m0_dat), .O_m0_ack(t_m0_ack), .O_m0_stall(t_m0_stall), .O_m0_err(t_m0_err),
    .I_m1_cyc(m1_cyc), .I_m1_stb(m1_stb), .I_m1_we(m1_we), .I_m1_adr(m1_adr), .I_m1_dat(m1_dat),
    .O_m1_dat(t_m1_dat), .O_m1_ack(t_m1_ack), .O_m1_stall(t_m1_stall), .O_m1_err(t_m1_err),
    .O_s_cyc(t_s_cyc), .O_s_stb(t_s_stb), .O_s_we(t_s_we), .O_s_adr(t_s_adr), .O_s_dat(t_s_dat),
    .I_s_dat(s_dat_i), .I_s_ack(s_ack), .I_s_stall(s_stall), .O_grant(t_grant)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    s_ack = 1;
    s_dat_i = 8'h3C;
    repeat (2) tick();
    #1;
    chk("rst_grant", d_grant, 0);
    chk("rst_s_cyc", d_s_cyc, 0);
    chk("rst_s_stb", d_s_stb, 0);
    chk("rst_acks", {d_m0_ack, d_m1_ack}, 0);
    chk("rst_stalls", {d_m0_stall, d_m1_stall}, 2'b11);
    chk("rst_errs", {d_m0_err, d_m1_err}, 0);
    chk("dat_bcast", {d_m0_dat, d_m1_dat}, 16'h3C3C);
    rst_n = 1;
    s_ack = 0;
    tick();
    chk("idle_grant", d_grant, 0);
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    tick();
    chk("tie_grant", d_grant, 2'b01);
    chk("tie_s_adr", d_s_adr, 32'h100);
    s_ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_m0_ack", d_m0_ack, 1);
      chk("rd_m1_ack", d_m1_ack, 0);
      chk("rd_m1_stall", d_m1_stall, 1);
      tick();
    end
    chk("hold_grant", d_grant, 2'b01);
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    chk("handoff_grant", d_grant, 2'b10);
    chk("handoff_s_cyc", d_s_cyc, 1);
    chk("handoff_s_adr", d_s_adr, 32'h200);
    m0_cyc = 1; m0_stb = 1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] eg;
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      chk("rr_grant", d_grant, eg);
      s_ack = 1;
      tick();
      chk("rr_hold", d_grant, eg);
      s_ack = 0;
      if (eg == 2'b10) begin m1_cyc = 0; m1_stb = 0; end
      else begin m0_cyc = 0; m0_stb = 0; end
      tick();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    end
    chk("rr_final", d_grant, 2'b10);
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    chk("rr_idle", d_grant, 0);
    m0_adr = 32'hDEAD0000; m0_dat = 8'h11;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h00001234; m1_dat = 8'hA5;
    tick();
    s_stall = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_m1_stall", d_m1_stall, 1);
      chk("st_m0_stall", d_m0_stall, 1);
      chk("st_m0_ack", d_m0_ack, 0);
      chk("st_bus", {d_s_cyc, d_s_stb, d_s_we, d_s_adr, d_s_dat}, {3'b111, 32'h00001234, 8'hA5});
      tick();
    end
    s_stall = 0; s_ack = 1;
    #1;
    chk("st_done", {d_m1_ack, d_m1_stall, d_m0_ack, d_m0_stall}, 4'b1001);
    tick();
    m1_cyc = 0; m1_stb = 0; m1_we = 0; s_ack = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40;
    tick();
    chk("to_grant", t_grant, 2'b01);
    for (int i = 0; i < 4; i++) begin
      chk("to_no_err", {t_m0_err, t_m1_err}, 0);
      if (i == 0) m1_cyc = 1;
      tick();
    end
    s_ack = 1;
    #1;
    chk("to_err0", {t_m0_err, t_m1_err}, 2'b10);
    chk("to_s_cyc", {t_s_cyc, t_s_stb}, 0);
    chk("late_ack", t_m0_ack, 0);
    tick();
    s_ack = 0;
    m0_cyc = 0; m0_stb = 0;
    #1;
    chk("to_next_owner", t_grant, 2'b10);
    chk("to_err_once", {t_m0_err, t_m1_err}, 0);
    repeat (4) tick();
    chk("to_err1", {t_m0_err, t_m1_err}, 2'b01);
    chk("to_s_cyc1", t_s_cyc, 0);
    tick();
    chk("to_idle", t_grant, 0);
    m1_cyc = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    m1_cyc = 1; m1_stb = 1;
    tick();
    chk("mr_own1", d_grant, 2'b10);
    rst_n = 0; s_ack = 1;
    tick();
    chk("mr_grant", d_grant, 0);
    chk("mr_s_cyc", d_s_cyc, 0);
    chk("mr_m1", {d_m1_stall, d_m1_ack}, 2'b10);
    rst_n = 1; s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("mr_tie", d_grant, 2'b01);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
